rbe_tcdm_responder: RTL and testbench

Synthesizable TCDM slave that answers the hci_core requests issued by the RBE streamer (source reads, sink writes) from a local single-ported wide scratch memory. It sits at the far end of the streamer's TCDM port, behind the streamer's own TCDM FIFO. It is used as a standalone RBE scratchpad and as the bring-up memory in RBE subsystem benches. Reads return full-width words with back-pressure through `r_ready`; writes are byte-enabled and retire on grant.

---
 rtl/rbe_package.sv | 17 +
 rtl/hci_core_intf.sv | 29 ++
 rtl/rbe_tcdm_resp_fifo.sv | 66 ++++++
 rtl/rbe_tcdm_responder.sv | 127 ++++++++++++
 tb/tb_rbe_tcdm_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rbe_package.sv
// RBE shared package: TCDM geometry constants and responder flag bundle.
// Imported by the TCDM responder and its response buffer.
package rbe_package;

  localparam int unsigned BITS_PER_TCDM_PORT = 32;
  localparam int unsigned NR_TCDM_PORTS      = 9;

  localparam logic TCDM_RESP_OPC_OOR = 1'b1;

  typedef struct packed {
    logic        busy;
    logic        oor_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
  } tcdm_resp_flags_t;

endpackage

// File: rtl/hci_core_intf.sv
// hci_core TCDM request/response bundle.
// Master drives requests, slave answers with grant and responses.
interface hci_core_intf #(
  parameter int unsigned DW = 288,
  parameter int unsigned AW = 32
);

  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;
  logic            r_valid;
  logic            r_ready;
  logic [DW-1:0]   r_data;
  logic            r_opc;

  modport master (
    output req, add, wen, be, data, r_ready,
    input  gnt, r_valid, r_data, r_opc
  );

  modport slave (
    input  req, add, wen, be, data, r_ready,
    output gnt, r_valid, r_data, r_opc
  );

endinterface

// File: rtl/rbe_tcdm_resp_fifo.sv
// Response buffer for the TCDM responder.
// Circular buffer, pointers wrap modulo DEPTH, exposes occupancy.
module rbe_tcdm_resp_fifo
  import rbe_package::*;
#(
  parameter  int unsigned W     = 289,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign w_wr_nxt = (r_wr == PW'(DEPTH - 1)) ?
                    '0 : r_wr + 1'b1;
  assign w_rd_nxt = (r_rd == PW'(DEPTH - 1)) ?
                    '0 : r_rd + 1'b1;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= w_wr_nxt;
      if (w_pop)  r_rd <= w_rd_nxt;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rbe_tcdm_responder.sv
// TCDM slave answering RBE streamer traffic from a wide scratch memory.
// Reads go mem -> output stage -> response buffer; writes retire on grant.
module rbe_tcdm_responder
  import rbe_package::*;
#(
  parameter int unsigned DW         =
    BITS_PER_TCDM_PORT * NR_TCDM_PORTS,
  parameter int unsigned AW         = 32,
  parameter int unsigned NB_WORDS   = 1024,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  hci_core_intf.slave      tcdm,
  output tcdm_resp_flags_t flags_o
);

  localparam int unsigned NBYTES = DW / 8;
  localparam int unsigned OFFS   = $clog2(NBYTES);
  localparam int unsigned IW     = $clog2(NB_WORDS);
  localparam int unsigned CW     = $clog2(RESP_DEPTH + 1);

  logic [DW-1:0] r_mem [NB_WORDS];
  logic [DW-1:0] r_s1_data;
  logic          r_s1_valid;
  logic          r_s1_oor;
  logic [31:0]   r_rd_cnt;
  logic [31:0]   r_wr_cnt;
  logic          r_oor_err;

  logic [IW-1:0] w_idx;
  logic          w_oor;
  logic          w_clr;
  logic [CW-1:0] w_outst;
  logic          w_gnt;
  logic          w_rd_gnt;
  logic          w_wr_gnt;
  logic          w_rvalid;
  logic          w_push;
  logic          w_pop;
  logic [DW:0]   w_head;
  logic [DW:0]   w_fifo_data;
  logic [CW-1:0] w_fifo_cnt;
  logic          w_fifo_empty;
  logic          w_fifo_full;

  assign w_idx   = tcdm.add[OFFS +: IW];
  assign w_oor   = |(tcdm.add >> (OFFS + IW));
  assign w_clr   = ~rst_ni | clear_i;
  assign w_outst = w_fifo_cnt + CW'(r_s1_valid);

  assign w_gnt = tcdm.req & enable_i & ~w_clr &
                 (~tcdm.wen |
                  (w_outst < CW'(RESP_DEPTH)));
  assign w_rd_gnt = w_gnt & tcdm.wen;
  assign w_wr_gnt = w_gnt & ~tcdm.wen;

  assign w_rvalid = ~w_fifo_empty | r_s1_valid;
  assign w_pop    = ~w_fifo_empty & tcdm.r_ready;
  // Output stage bypasses the buffer when it is empty and drained now.
  assign w_push   = r_s1_valid &
                    ~(w_fifo_empty & tcdm.r_ready);

  always_comb begin
    w_head = '0;
    if (!w_fifo_empty) w_head = w_fifo_data;
    else if (r_s1_valid) w_head = {r_s1_oor, r_s1_data};
  end

  assign tcdm.gnt     = w_gnt;
  assign tcdm.r_valid = w_rvalid;
  assign tcdm.r_data  = w_head[DW-1:0];
  assign tcdm.r_opc   = w_head[DW];

  always_ff @(posedge clk_i) begin
    if (w_wr_gnt && !w_oor) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (tcdm.be[b])
          r_mem[w_idx][b*8 +: 8] <= tcdm.data[b*8 +: 8];
      end
    end
    if (w_rd_gnt)
      r_s1_data <= w_oor ? '0 : r_mem[w_idx];
  end

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_s1_valid <= 1'b0;
      r_s1_oor   <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_oor_err  <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_gnt;
      if (w_rd_gnt)
        r_s1_oor <= w_oor ? TCDM_RESP_OPC_OOR
                          : ~TCDM_RESP_OPC_OOR;
      if (w_rd_gnt) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_wr_gnt) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_gnt && w_oor) r_oor_err <= 1'b1;
    end
  end

  rbe_tcdm_resp_fifo #(
    .W     (DW + 1),
    .DEPTH (RESP_DEPTH)
  ) i_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clear (clear_i),
    .i_push  (w_push),
    .i_data  ({r_s1_oor, r_s1_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign flags_o.busy    = (w_outst != '0);
  assign flags_o.oor_err = r_oor_err;
  assign flags_o.rd_cnt  = r_rd_cnt;
  assign flags_o.wr_cnt  = r_wr_cnt;

endmodule

// File: tb/tb_rbe_tcdm_responder.sv
// Bench for rbe_tcdm_responder: vector table plus corner sequences.
// Read responses are scored against a queue filled at grant time.
module tb_rbe_tcdm_responder;
  import rbe_package::*;

  localparam int DW = 288;
  localparam int NB = 1024;
  localparam int OFFS = 6;

  typedef struct {
    logic          wen;
    logic [31:0]   add;
    logic [35:0]   be;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
    logic          opc;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          opc;
  } resp_t;

  logic clk;
  logic rst_n;
  logic clear;
  logic enable;
  tcdm_resp_flags_t flags;

  hci_core_intf #(.DW(DW), .AW(32)) tcdm_if ();

  rbe_tcdm_responder dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .enable_i (enable),
    .tcdm     (tcdm_if),
    .flags_o  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  resp_t sbq[$];
  vec_t tbl[13];

  localparam logic [35:0] BE1 = '1;

  function automatic logic [31:0] wa(int idx);
    return 32'(idx) << OFFS;
  endfunction

  function automatic logic [DW-1:0] sdat(int i);
    return {9{32'hBEEF0000 | 32'(i)}};
  endfunction

  task automatic chk(string nm, logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [35:0] b,
                        input logic [DW-1:0] d,
                        input logic [DW-1:0] e,
                        input logic o);
    bit ok = 0;
    resp_t r;
    tcdm_if.req  = 1'b1;
    tcdm_if.wen  = w;
    tcdm_if.add  = a;
    tcdm_if.be   = b;
    tcdm_if.data = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (tcdm_if.gnt) begin
        if (w) begin
          r.data = e;
          r.opc  = o;
          sbq.push_back(r);
        end
        ok = 1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    tcdm_if.req = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout add %h", a);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    chk("drain_left", DW'(sbq.size()), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_hold(input logic [31:0] a,
                         input logic exp_gnt,
                         input logic [DW-1:0] e);
    resp_t r;
    tcdm_if.req = 1'b1;
    tcdm_if.wen = 1'b1;
    tcdm_if.add = a;
    @(negedge clk);
    chk("bp_gnt", DW'(tcdm_if.gnt), DW'(exp_gnt));
    if (tcdm_if.gnt) begin
      r.data = e;
      r.opc  = 1'b0;
      sbq.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resp_t r;
    tbl[0]  = '{0, wa(5), BE1, {36{8'hA5}}, '0, 0};
    tbl[1]  = '{1, wa(5), '0, '0, {36{8'hA5}}, 0};
    tbl[2]  = '{0, wa(0), BE1, '0, '0, 0};
    tbl[3]  = '{0, wa(0), 36'h1, {36{8'h3C}}, '0, 0};
    tbl[4]  = '{1, wa(0), '0, '0, DW'(8'h3C), 0};
    tbl[5]  = '{0, wa(7), BE1, {36{8'h11}}, '0, 0};
    tbl[6]  = '{0, wa(7), 36'hF0, {36{8'hFF}}, '0, 0};
    tbl[7]  = '{1, wa(7), '0, '0,
                {{28{8'h11}}, {4{8'hFF}}, {4{8'h11}}}, 0};
    tbl[8]  = '{0, wa(1023), BE1, {9{32'hCAFEF00D}}, '0, 0};
    tbl[9]  = '{1, wa(1023) | 32'h3F, '0, '0,
                {9{32'hCAFEF00D}}, 0};
    tbl[10] = '{1, wa(NB), '0, '0, '0, 1};
    tbl[11] = '{0, wa(NB) | wa(5), BE1, '1, '0, 0};
    tbl[12] = '{1, wa(5), '0, '0, {36{8'hA5}}, 0};

    fork
      forever begin
        @(negedge clk);
        if (tcdm_if.r_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp got %h",
                     tcdm_if.r_data);
          end else if (tcdm_if.r_ready) begin
            r = sbq.pop_front();
            chk("r_data", tcdm_if.r_data, r.data);
            chk("r_opc", DW'(tcdm_if.r_opc), DW'(r.opc));
          end else begin
            chk("hold_data", tcdm_if.r_data, sbq[0].data);
          end
        end
      end
    join_none

    rst_n = 1'b0;
    clear = 1'b0;
    enable = 1'b1;
    tcdm_if.req = 1'b1;
    tcdm_if.wen = 1'b1;
    tcdm_if.add = '0;
    tcdm_if.be = '0;
    tcdm_if.data = '0;
    tcdm_if.r_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", DW'(tcdm_if.gnt), '0);
    end
    chk("rst_rvalid", DW'(tcdm_if.r_valid), '0);
    chk("rst_rdata", tcdm_if.r_data, '0);
    chk("rst_opc", DW'(tcdm_if.r_opc), '0);
    chk("rst_flags", DW'(flags), '0);
    @(posedge clk);
    #1;
    tcdm_if.req = 1'b0;
    rst_n = 1'b1;

    enable = 1'b0;
    tcdm_if.req = 1'b1;
    @(negedge clk);
    chk("dis_gnt", DW'(tcdm_if.gnt), '0);
    @(posedge clk);
    #1;
    tcdm_if.req = 1'b0;
    enable = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_req(tbl[i].wen, tbl[i].add, tbl[i].be,
             tbl[i].data, tbl[i].exp, tbl[i].opc);
      if (tbl[i].wen)
        chk("rd_latency", DW'(tcdm_if.r_valid), DW'(1));
    end
    drain();
    chk("wr_cnt", DW'(flags.wr_cnt), DW'(7));
    chk("rd_cnt", DW'(flags.rd_cnt), DW'(6));
    chk("oor_err", DW'(flags.oor_err), DW'(1));
    chk("idle_busy", DW'(flags.busy), '0);
    repeat (3) @(posedge clk);
    #1;
    chk("oor_sticky", DW'(flags.oor_err), DW'(1));
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_oor", DW'(flags.oor_err), '0);
    chk("clr_cnt", DW'({flags.rd_cnt, flags.wr_cnt}), '0);

    tcdm_if.r_ready = 1'b0;
    rd_hold(wa(5), 1, {36{8'hA5}});
    rd_hold(wa(0), 1, DW'(8'h3C));
    for (int k = 0; k < 2; k++) begin
      rd_hold(wa(7), 0, '0);
      chk("bp_busy", DW'(flags.busy), DW'(1));
    end
    tcdm_if.wen = 1'b0;
    tcdm_if.add = wa(20);
    tcdm_if.be = BE1;
    tcdm_if.data = '1;
    @(negedge clk);
    chk("full_wr_gnt", DW'(tcdm_if.gnt), DW'(1));
    @(posedge clk);
    #1;
    rd_hold(wa(7), 0, '0);
    tcdm_if.req = 1'b0;
    tcdm_if.r_ready = 1'b1;
    do_req(1, wa(7), '0, '0,
           {{28{8'h11}}, {4{8'hFF}}, {4{8'h11}}}, 0);
    do_req(1, wa(1023), '0, '0, {9{32'hCAFEF00D}}, 0);
    drain();
    chk("bp_rd_cnt", DW'(flags.rd_cnt), DW'(4));

    for (int i = 0; i < 16; i++)
      do_req(0, wa(16 + i), BE1, sdat(i), '0, 0);
    tcdm_if.req = 1'b1;
    tcdm_if.wen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tcdm_if.add = wa(16 + i);
      @(negedge clk);
      chk("stream_gnt", DW'(tcdm_if.gnt), DW'(1));
      if (tcdm_if.gnt) begin
        r.data = sdat(i);
        r.opc = 1'b0;
        sbq.push_back(r);
      end
      @(posedge clk);
      #1;
    end
    tcdm_if.req = 1'b0;
    drain();

    tcdm_if.r_ready = 1'b0;
    do_req(1, wa(5), '0, '0, {36{8'hA5}}, 0);
    do_req(1, wa(0), '0, '0, DW'(8'h3C), 0);
    clear = 1'b1;
    tcdm_if.req = 1'b1;
    tcdm_if.wen = 1'b1;
    @(negedge clk);
    chk("clr_gnt", DW'(tcdm_if.gnt), '0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    tcdm_if.req = 1'b0;
    sbq.delete();
    chk("clr_rvalid", DW'(tcdm_if.r_valid), '0);
    chk("clr_busy", DW'(flags.busy), '0);
    chk("clr_cnt2", DW'({flags.rd_cnt, flags.wr_cnt}), '0);
    tcdm_if.r_ready = 1'b1;
    do_req(1, wa(5), '0, '0, {36{8'hA5}}, 0);
    do_req(1, wa(0), '0, '0, DW'(8'h3C), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
